rdmap_ddr_reader: RTL and testbench

- Read-back counterpart of the rdmap cache writer: fetches one stored RD map frame (16384 x 128-bit beats, 256 KiB) from DDR for a given wave_position.
- Issues 64-bit DDR read commands into the read-command FIFO and pops 128-bit beats from the read-data FIFO (first-word-fall-through).
- Unpacks each beat into four 32-bit words on an AXI-stream master toward the PS/debug path, then raises a frame-done interrupt.

---
 rtl/rdmap_pkg.sv | 29 ++
 rtl/rdmap_beat_unpack.sv | 55 +++++
 rtl/rdmap_ddr_reader.sv | 137 +++++++++++++
 tb/tb_rdmap_ddr_reader.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rdmap_pkg.sv
// Shared RD map cache definitions: frame geometry, DDR placement and the
// 64-bit DataMover-style read/write command word used by reader and writer.
package rdmap_pkg;

  localparam int unsigned RDMAP_BEATS_PER_FRAME = 16384;
  localparam logic [11:0] RDMAP_CMD_BTT_M1      = 12'd4095;
  localparam logic [2:0]  RDMAP_DDR_BASE_HI     = 3'b011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } rdmap_state_e;

  // Bit 31 carries the INCR flag, so address bits [19:18] are not encodable;
  // the RD map layout never uses them (blocks sit in [17:12], slot above 20).
  function automatic logic [63:0] rdmap_build_cmd(input logic [7:0] wp,
                                                  input logic [5:0] blk);
    logic [63:0] cmd;
    cmd          = '0;
    cmd[11:0]    = RDMAP_CMD_BTT_M1;
    cmd[29:24]   = blk;
    cmd[30]      = 1'b0;
    cmd[31]      = 1'b1;
    cmd[43:32]   = {RDMAP_DDR_BASE_HI, wp, 1'b1};
    return cmd;
  endfunction

endpackage

// File: rtl/rdmap_beat_unpack.sv
// Splits 128-bit beats from a first-word-fall-through FIFO into four 32-bit
// AXI-stream words, low word first, refilling without bubbles.
module rdmap_beat_unpack
  import rdmap_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         pop_allow,
  input  logic [127:0] fifo_dout,
  input  logic         fifo_empty,
  output logic         fifo_rd_en,
  output logic [31:0]  tdata,
  output logic         tvalid,
  input  logic         tready
);

  logic [127:0] hold_q;
  logic         hold_vld;
  logic [1:0]   idx;
  logic         word_hs;
  logic         last_word;

  assign word_hs   = hold_vld && tready;
  assign last_word = (idx == 2'd3);
  assign tvalid    = hold_vld;

  // Refill on the same edge the fourth word leaves so the stream never gaps.
  assign fifo_rd_en = pop_allow && !fifo_empty && (!hold_vld || (last_word && word_hs));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q   <= '0;
      hold_vld <= 1'b0;
      idx      <= 2'd0;
    end else if (fifo_rd_en) begin
      hold_q   <= fifo_dout;
      hold_vld <= 1'b1;
      idx      <= 2'd0;
    end else if (word_hs) begin
      idx <= idx + 2'd1;
      if (last_word) hold_vld <= 1'b0;
    end
  end

  always_comb begin
    tdata = hold_q[31:0];
    case (idx)
      2'd1:    tdata = hold_q[63:32];
      2'd2:    tdata = hold_q[95:64];
      2'd3:    tdata = hold_q[127:96];
      default: tdata = hold_q[31:0];
    endcase
  end

endmodule

// File: rtl/rdmap_ddr_reader.sv
// Fetches one stored RD map frame from DDR: issues block read commands with a
// bounded number in flight and streams the returned beats out as 32-bit words.
module rdmap_ddr_reader
  import rdmap_pkg::*;
#(
  parameter int unsigned BEATS_PER_CMD   = 256,
  parameter int unsigned NUM_CMDS        = RDMAP_BEATS_PER_FRAME / BEATS_PER_CMD,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned IRQ_CYCLES      = 24
)(
  input  logic         clk,
  input  logic         rst,
  input  logic         rd_start,
  input  logic [7:0]   wave_position,
  output logic         rd_busy,
  output logic [63:0]  fifo_din_cmd_rd,
  output logic         fifo_wr_en_cmd_rd,
  input  logic         fifo_full_cmd_rd,
  input  logic [127:0] fifo_dout_rd_rdmap,
  input  logic         fifo_empty_rd_rdmap,
  output logic         fifo_rd_en_rd_rdmap,
  output logic [31:0]  rdmap_rd_tdata,
  output logic         rdmap_rd_tvalid,
  output logic         rdmap_rd_tlast,
  input  logic         rdmap_rd_tready,
  output logic         rdmap_rd_irq
);

  localparam int unsigned TOTAL_BEATS = NUM_CMDS * BEATS_PER_CMD;
  localparam int unsigned TOTAL_WORDS = TOTAL_BEATS * 4;
  localparam int unsigned CMD_W       = $clog2(NUM_CMDS + 1);
  localparam int unsigned BEAT_W      = $clog2(TOTAL_BEATS + 1);
  localparam int unsigned WORD_W      = $clog2(TOTAL_WORDS);
  localparam int unsigned BPC_W       = $clog2(BEATS_PER_CMD);
  localparam int unsigned OUT_W       = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned IRQ_W       = $clog2(IRQ_CYCLES);

  localparam logic [CMD_W-1:0]  NUM_CMDS_C    = CMD_W'(NUM_CMDS);
  localparam logic [BEAT_W-1:0] TOTAL_BEATS_C = BEAT_W'(TOTAL_BEATS);
  localparam logic [WORD_W-1:0] LAST_WORD_C   = WORD_W'(TOTAL_WORDS - 1);
  localparam logic [OUT_W-1:0]  MAX_OUT_C     = OUT_W'(MAX_OUTSTANDING);
  localparam logic [IRQ_W-1:0]  IRQ_LAST_C    = IRQ_W'(IRQ_CYCLES - 1);
  localparam logic [63:0]       CMD_RESET_C   = {52'h0, RDMAP_CMD_BTT_M1};

  rdmap_state_e      state;
  logic [7:0]        wp_q;
  logic [CMD_W-1:0]  cmd_cnt;
  logic [OUT_W-1:0]  outstanding;
  logic [BEAT_W-1:0] beat_cnt;
  logic [WORD_W-1:0] word_cnt;
  logic [IRQ_W-1:0]  irq_cnt;

  logic pop_allow;
  logic cmd_issue;
  logic cmd_retire;
  logic word_hs;

  // Popping stops once the whole frame has been taken, so stray beats stay put.
  assign pop_allow  = (state == ST_RUN) && (beat_cnt < TOTAL_BEATS_C);
  assign cmd_issue  = (state == ST_RUN) && (cmd_cnt < NUM_CMDS_C) &&
                      !fifo_full_cmd_rd && (outstanding < MAX_OUT_C);
  assign cmd_retire = fifo_rd_en_rd_rdmap && (beat_cnt[BPC_W-1:0] == '1);
  assign word_hs    = rdmap_rd_tvalid && rdmap_rd_tready;
  assign rdmap_rd_tlast = rdmap_rd_tvalid && (word_cnt == LAST_WORD_C);

  rdmap_beat_unpack u_unpack (
    .clk        (clk),
    .rst        (rst),
    .pop_allow  (pop_allow),
    .fifo_dout  (fifo_dout_rd_rdmap),
    .fifo_empty (fifo_empty_rd_rdmap),
    .fifo_rd_en (fifo_rd_en_rd_rdmap),
    .tdata      (rdmap_rd_tdata),
    .tvalid     (rdmap_rd_tvalid),
    .tready     (rdmap_rd_tready)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= ST_IDLE;
      wp_q              <= '0;
      cmd_cnt           <= '0;
      outstanding       <= '0;
      beat_cnt          <= '0;
      word_cnt          <= '0;
      irq_cnt           <= '0;
      rd_busy           <= 1'b0;
      rdmap_rd_irq      <= 1'b0;
      fifo_wr_en_cmd_rd <= 1'b0;
      fifo_din_cmd_rd   <= CMD_RESET_C;
    end else begin
      fifo_wr_en_cmd_rd <= cmd_issue;
      if (cmd_issue) begin
        fifo_din_cmd_rd <= rdmap_build_cmd(wp_q, 6'(cmd_cnt));
        cmd_cnt         <= cmd_cnt + CMD_W'(1);
      end
      if (cmd_issue && !cmd_retire)
        outstanding <= outstanding + OUT_W'(1);
      else if (!cmd_issue && cmd_retire)
        outstanding <= outstanding - OUT_W'(1);
      if (fifo_rd_en_rd_rdmap) beat_cnt <= beat_cnt + BEAT_W'(1);
      if (word_hs)             word_cnt <= word_cnt + WORD_W'(1);

      case (state)
        ST_IDLE: begin
          if (rd_start) begin
            wp_q        <= wave_position;
            cmd_cnt     <= '0;
            outstanding <= '0;
            beat_cnt    <= '0;
            word_cnt    <= '0;
            rd_busy     <= 1'b1;
            state       <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (word_hs && (word_cnt == LAST_WORD_C)) begin
            rd_busy      <= 1'b0;
            rdmap_rd_irq <= 1'b1;
            irq_cnt      <= '0;
            state        <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (irq_cnt == IRQ_LAST_C) begin
            rdmap_rd_irq <= 1'b0;
            state        <= ST_IDLE;
          end else begin
            irq_cnt <= irq_cnt + IRQ_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rdmap_ddr_reader.sv
// Bench for rdmap_ddr_reader: address-keyed DDR/FIFO model plus a stream
// scoreboard, driven through directed frame scenarios.
module tb_rdmap_ddr_reader;

  localparam int NCMD        = 8;
  localparam int BPC         = 256;
  localparam int MAXO        = 2;
  localparam int IRQN        = 24;
  localparam int TOTAL_WORDS = NCMD * BPC * 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         rd_start;
  logic [7:0]   wave_position;
  logic         rd_busy;
  logic [63:0]  fifo_din_cmd_rd;
  logic         fifo_wr_en_cmd_rd;
  logic         fifo_full_cmd_rd;
  logic [127:0] fifo_dout_rd_rdmap;
  logic         fifo_empty_rd_rdmap;
  logic         fifo_rd_en_rd_rdmap;
  logic [31:0]  rdmap_rd_tdata;
  logic         rdmap_rd_tvalid;
  logic         rdmap_rd_tlast;
  logic         rdmap_rd_tready;
  logic         rdmap_rd_irq;

  always #5 clk = ~clk;

  rdmap_ddr_reader #(
    .BEATS_PER_CMD   (BPC),
    .NUM_CMDS        (NCMD),
    .MAX_OUTSTANDING (MAXO),
    .IRQ_CYCLES      (IRQN)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .rd_start            (rd_start),
    .wave_position       (wave_position),
    .rd_busy             (rd_busy),
    .fifo_din_cmd_rd     (fifo_din_cmd_rd),
    .fifo_wr_en_cmd_rd   (fifo_wr_en_cmd_rd),
    .fifo_full_cmd_rd    (fifo_full_cmd_rd),
    .fifo_dout_rd_rdmap  (fifo_dout_rd_rdmap),
    .fifo_empty_rd_rdmap (fifo_empty_rd_rdmap),
    .fifo_rd_en_rd_rdmap (fifo_rd_en_rd_rdmap),
    .rdmap_rd_tdata      (rdmap_rd_tdata),
    .rdmap_rd_tvalid     (rdmap_rd_tvalid),
    .rdmap_rd_tlast      (rdmap_rd_tlast),
    .rdmap_rd_tready     (rdmap_rd_tready),
    .rdmap_rd_irq        (rdmap_rd_irq)
  );

  int       vectors = 0;
  int       miscompares = 0;
  int       frame_seq = 0;
  logic [7:0] exp_wp = 8'h00;
  int       gap = 1;
  bit       rand_ready = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Byte address of a frame slot in DDR.
  function automatic logic [31:0] frame_base(input logic [7:0] wp);
    return 32'h6000_0000 | {3'b000, wp, 21'h0} | 32'h0010_0000;
  endfunction

  // Command word: address bits [31:20] land in [43:32], block in [29:24].
  function automatic logic [63:0] exp_cmd(input logic [7:0] wp, input int n);
    logic [31:0] b;
    b = frame_base(wp);
    return {20'h0, b[31:20], 1'b1, 1'b0, 6'(n), 12'h000, 12'hFFF};
  endfunction

  // DDR + FIFO model: memory word at byte address A holds A itself.
  logic [127:0] data_q[$];
  logic [127:0] pend_q[$];
  int wr_n = 0, cmp_n = 0, cmp_lag = 0, pop_n = 0, mem_seq = 0, tick = 0;
  bit full_prev = 1'b0;
  logic [31:0] first_addr = '0, last_addr = '0;

  initial begin
    logic        s_wr, s_rd, s_full;
    logic [63:0] s_din;
    logic [31:0] addr, a;
    fifo_empty_rd_rdmap = 1'b1;
    fifo_dout_rd_rdmap  = '0;
    forever begin
      @(negedge clk);
      s_wr = fifo_wr_en_cmd_rd; s_din = fifo_din_cmd_rd;
      s_rd = fifo_rd_en_rd_rdmap; s_full = fifo_full_cmd_rd;
      if (rst) begin
        data_q.delete(); pend_q.delete(); full_prev = 1'b0;
      end else begin
        if (mem_seq != frame_seq) begin
          mem_seq = frame_seq; wr_n = 0; cmp_n = 0; cmp_lag = 0; pop_n = 0;
        end
        if (full_prev) check("cmd_wr_while_full", 64'(s_wr), 64'd0);
        if (s_wr) begin
          addr = {s_din[43:32], 2'b00, s_din[29:24], 12'h000};
          check("cmd_word", s_din, exp_cmd(exp_wp, wr_n));
          check("outstanding_before_issue", 64'((wr_n - cmp_lag) < MAXO), 64'd1);
          if (wr_n == 0) first_addr = addr;
          last_addr = addr;
          wr_n++;
          for (int b = 0; b < BPC; b++) begin
            a = addr + 32'(16 * b);
            pend_q.push_back({a + 32'd12, a + 32'd8, a + 32'd4, a});
          end
        end
        cmp_lag = cmp_n;
        if (s_rd) begin
          check("pop_nonempty", 64'(data_q.size() > 0), 64'd1);
          pop_n++;
          if (pop_n % BPC == 0) cmp_n++;
        end
        full_prev = s_full;
      end
      @(posedge clk);
      #1;
      if (!rst) begin
        if (s_rd && data_q.size() > 0) void'(data_q.pop_front());
        tick++;
        if (pend_q.size() > 0 && (tick % gap) == 0) data_q.push_back(pend_q.pop_front());
      end
      fifo_empty_rd_rdmap = (data_q.size() == 0);
      fifo_dout_rd_rdmap  = fifo_empty_rd_rdmap ? 128'h0 : data_q[0];
    end
  end

  initial begin
    rdmap_rd_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      rdmap_rd_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Stream scoreboard: word n of a frame must be frame_base + 4n.
  int out_idx = 0, tlast_n = 0, cmp_seq = 0;
  bit prev_stall = 1'b0;
  logic [31:0] prev_data = '0;
  logic        prev_last = 1'b0;
  logic [31:0] first_word = '0, last_word = '0;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (cmp_seq != frame_seq) begin
          cmp_seq = frame_seq; out_idx = 0; tlast_n = 0;
        end
        if (prev_stall) begin
          check("stall_tvalid", 64'(rdmap_rd_tvalid), 64'd1);
          check("stall_tdata", 64'(rdmap_rd_tdata), 64'(prev_data));
          check("stall_tlast", 64'(rdmap_rd_tlast), 64'(prev_last));
        end
        if (rdmap_rd_tvalid) begin
          check("tdata", 64'(rdmap_rd_tdata), 64'(frame_base(exp_wp) + 32'(4 * out_idx)));
          check("tlast", 64'(rdmap_rd_tlast), 64'(out_idx == TOTAL_WORDS - 1));
          if (rdmap_rd_tready) begin
            if (out_idx == 0) first_word = rdmap_rd_tdata;
            last_word = rdmap_rd_tdata;
            if (rdmap_rd_tlast) tlast_n++;
            out_idx++;
          end
        end else begin
          check("tlast_idle", 64'(rdmap_rd_tlast), 64'd0);
        end
        prev_stall = rdmap_rd_tvalid && !rdmap_rd_tready;
        prev_data  = rdmap_rd_tdata;
        prev_last  = rdmap_rd_tlast;
      end
    end
  end

  task automatic start_frame(input logic [7:0] wp);
    wave_position = wp;
    exp_wp        = wp;
    frame_seq++;
    rd_start = 1'b1;
    @(posedge clk); #1;
    rd_start = 1'b0;
  endtask

  task automatic pulse_start(input logic [7:0] wp);
    wave_position = wp;
    rd_start = 1'b1;
    @(posedge clk); #1;
    rd_start = 1'b0;
  endtask

  task automatic wait_words(input int n);
    int cyc = 0;
    while (out_idx < n && cyc < 30000) begin
      @(posedge clk); cyc++;
    end
    #1;
    if (out_idx < n) check("wait_words_timeout", 64'(out_idx), 64'(n));
  endtask

  task automatic wait_frame(input bit poke_done);
    int cyc = 0;
    int n = 0;
    while (!rdmap_rd_irq && cyc < 40000) begin
      @(negedge clk); cyc++;
    end
    if (!rdmap_rd_irq) begin
      check("frame_timeout", 64'd0, 64'd1);
    end else begin
      check("busy_low_at_irq", 64'(rd_busy), 64'd0);
      check("word_total", 64'(out_idx), 64'(TOTAL_WORDS));
      check("tlast_count", 64'(tlast_n), 64'd1);
      check("cmd_total", 64'(wr_n), 64'(NCMD));
      if (poke_done) begin
        fork
          begin
            @(posedge clk); #1;
            wave_position = 8'h99; rd_start = 1'b1;
            @(posedge clk); #1;
            rd_start = 1'b0;
          end
        join_none
      end
      while (rdmap_rd_irq && n < 100) begin
        n++; @(negedge clk);
      end
      check("irq_length", 64'(n), 64'(IRQN));
    end
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs();
    check("rst_busy", 64'(rd_busy), 64'd0);
    check("rst_cmd_din", fifo_din_cmd_rd, 64'h0000_0000_0000_0FFF);
    check("rst_cmd_wr", 64'(fifo_wr_en_cmd_rd), 64'd0);
    check("rst_rd_en", 64'(fifo_rd_en_rd_rdmap), 64'd0);
    check("rst_tdata", 64'(rdmap_rd_tdata), 64'd0);
    check("rst_tvalid", 64'(rdmap_rd_tvalid), 64'd0);
    check("rst_tlast", 64'(rdmap_rd_tlast), 64'd0);
    check("rst_irq", 64'(rdmap_rd_irq), 64'd0);
  endtask

  initial begin
    rst = 1'b1; rd_start = 1'b0; wave_position = 8'h00; fifo_full_cmd_rd = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    rst = 1'b0;
    @(posedge clk); #1;

    // Frame at slot 0x05, full-rate ready
    start_frame(8'h05);
    wait_frame(1'b0);
    check("first_cmd_addr", 64'(first_addr), 64'h60B0_0000);
    check("last_cmd_addr", 64'(last_addr), 64'h60B0_7000);
    check("first_word", 64'(first_word), 64'h60B0_0000);
    check("last_word", 64'(last_word), 64'h60B0_7FFC);

    // Slow data return keeps commands throttled by the outstanding limit
    gap = 6;
    start_frame(8'h12);
    wait_frame(1'b0);
    gap = 1;

    // Random backpressure, command FIFO full window, stray starts in RUN/DONE
    rand_ready = 1'b1;
    start_frame(8'h40);
    wait_words(1000);
    pulse_start(8'h77);
    wait_words(2000);
    fifo_full_cmd_rd = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    fifo_full_cmd_rd = 1'b0;
    wait_frame(1'b1);
    rand_ready = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("idle_after_done_poke", 64'(rd_busy), 64'd0);
    check("no_extra_cmds", 64'(wr_n), 64'(NCMD));

    // A new start picks up the new slot
    start_frame(8'hA3);
    wait_frame(1'b0);
    check("second_slot_addr", 64'(first_addr), 64'h7470_0000);

    // Abort mid-frame, then a clean frame
    start_frame(8'h3C);
    wait_words(3000);
    rst = 1'b1;
    #1;
    check_reset_outputs();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    start_frame(8'h3C);
    wait_frame(1'b0);
    check("post_reset_first_word", 64'(first_word), 64'h6790_0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
